// File: rtl/click_fifo_pkg.sv
// click_pkg: shared definitions for the click FIFO slice.
//   CLICK_SYNC_STAGES : flop count of each click_sync synchroniser
//   click_pend()      : a 2-phase channel has a pending transfer when req and ack differ
package click_pkg;

    localparam int CLICK_SYNC_STAGES = 2;

    function automatic logic click_pend(input logic req, input logic ack);
        return req ^ ack;
    endfunction

endpackage

// File: rtl/click_fifo_if.sv
// click_fifo_if: the two 2-phase bundled-data channels of the click FIFO.
//   in_data / in_req / in_ack    : producer side, one word per in_req toggle
//   out_data / out_req / out_ack : consumer side, one word per out_req toggle
// Modports:
//   master : producer/consumer environment (drives in_data, in_req, out_ack)
//   slave  : the FIFO itself (drives in_ack, out_data, out_req)
interface click_fifo_if #(
    parameter int DW = 2
);
    logic [DW-1:0] in_data;
    logic          in_req;
    logic          in_ack;
    logic [DW-1:0] out_data;
    logic          out_req;
    logic          out_ack;

    modport master (
        output in_data,
        output in_req,
        input  in_ack,
        input  out_data,
        input  out_req,
        output out_ack
    );

    modport slave (
        input  in_data,
        input  in_req,
        output in_ack,
        output out_data,
        output out_req,
        input  out_ack
    );
endinterface

// File: rtl/click_fifo_sync.sv
// click_sync: 1-bit multi-flop synchroniser for a 2-phase handshake line.
//   clk   : destination clock
//   reset : synchronous, active-high; clears every stage to 0
//   d     : asynchronous input
//   q     : synchronised output, CLICK_SYNC_STAGES cycles behind d
module click_sync
    import click_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [CLICK_SYNC_STAGES-1:0] stages;

    always_ff @(posedge clk) begin
        if (reset) begin
            stages <= '0;
        end else begin
            stages <= {stages[CLICK_SYNC_STAGES-2:0], d};
        end
    end

    assign q = stages[CLICK_SYNC_STAGES-1];
endmodule

// File: rtl/click_fifo.sv
// click_fifo: DEPTH-entry, DW-bit FIFO with 2-phase click handshakes on both sides.
//   clk   : single clock, all state changes on its rising edge
//   reset : synchronous, active-high; discards all words, both channels to phase 0
//   bus   : click_fifo_if.slave (in_data/in_req/in_ack, out_data/out_req/out_ack)
//   level : words in storage (0..DEPTH), not counting the output register
//   full  : level == DEPTH
//   empty : level == 0
// Build option: define CLICK_SYNC_EN to pass in_req and out_ack through
// click_sync synchronisers (adds 2 cycles of latency in each direction).
module click_fifo
    import click_pkg::*;
#(
    parameter int DW    = 2,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    click_fifo_if.slave   bus,
    output logic [CW-1:0] level,
    output logic          full,
    output logic          empty
);
    logic [DW-1:0] mem [0:DEPTH-1];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          in_req_i;
    logic          out_ack_i;
    logic          wr;
    logic          rd;

`ifdef CLICK_SYNC_EN
    click_sync u_sync_in_req (
        .clk   (clk),
        .reset (reset),
        .d     (bus.in_req),
        .q     (in_req_i)
    );

    click_sync u_sync_out_ack (
        .clk   (clk),
        .reset (reset),
        .d     (bus.out_ack),
        .q     (out_ack_i)
    );
`else
    assign in_req_i  = bus.in_req;
    assign out_ack_i = bus.out_ack;
`endif

    assign full  = (level == CW'(DEPTH));
    assign empty = (level == '0);

    // The output register counts as busy until the consumer acks it; a full
    // store blocks writes even when a read frees a slot on the same edge,
    // and an empty store never forwards the incoming word directly.
    assign wr = click_pend(in_req_i, bus.in_ack) && !full;
    assign rd = !click_pend(bus.out_req, out_ack_i) && !empty;

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.in_ack   <= 1'b0;
            bus.out_req  <= 1'b0;
            bus.out_data <= '0;
            wptr         <= '0;
            rptr         <= '0;
            level        <= '0;
        end else begin
            if (wr) begin
                bus.in_ack <= ~bus.in_ack;
                wptr       <= (wptr == AW'(DEPTH - 1)) ? '0 : wptr + AW'(1);
            end
            if (rd) begin
                bus.out_data <= mem[rptr];
                bus.out_req  <= ~bus.out_req;
                rptr         <= (rptr == AW'(DEPTH - 1)) ? '0 : rptr + AW'(1);
            end
            case ({wr, rd})
                2'b10:   level <= level + CW'(1);
                2'b01:   level <= level - CW'(1);
                default: level <= level;
            endcase
        end
    end
endmodule

// File: tb/tb_click_fifo.sv
// tb_click_fifo: self-checking bench for click_fifo (DW=2, DEPTH=4).
// Words are pushed to a scoreboard queue when offered on in_req and popped
// when the FIFO presents them on out_req. Honours CLICK_SYNC_EN for the
// expected handshake latencies.
module tb_click_fifo;
    localparam int DW    = 2;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

`ifdef CLICK_SYNC_EN
    localparam int IN_LAT  = 3;
    localparam int OUT_LAT = 4;
`else
    localparam int IN_LAT  = 1;
    localparam int OUT_LAT = 2;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [CW-1:0] level;
    logic          full;
    logic          empty;

    int n_vectors     = 0;
    int n_miscompares = 0;

    logic [DW-1:0] sb [$];

    click_fifo_if #(.DW(DW)) bus ();

    click_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one word and wait (bounded) for its acknowledge.
    task automatic send_word(input logic [DW-1:0] w);
        int k;
        bus.in_data = w;
        bus.in_req  = ~bus.in_req;
        sb.push_back(w);
        k = 0;
        while (bus.in_ack !== bus.in_req && k < 40) begin
            step();
            k++;
        end
        n_vectors++;
        if (bus.in_ack !== bus.in_req) begin
            n_miscompares++;
            $display("[TB] FAIL in_ack_timeout: in_ack=%b required %b", bus.in_ack, bus.in_req);
        end
    endtask

    // Wait (bounded) for a presented word, compare with the scoreboard, release it.
    task automatic recv_word();
        int k;
        logic [DW-1:0] exp;
        k = 0;
        while (bus.out_req === bus.out_ack && k < 40) begin
            step();
            k++;
        end
        exp = (sb.size() > 0) ? sb.pop_front() : 'x;
        n_vectors++;
        if (bus.out_req === bus.out_ack) begin
            n_miscompares++;
            $display("[TB] FAIL out_req_timeout: out_req=%b required %b", bus.out_req, ~bus.out_ack);
        end else if (bus.out_data !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL out_data: got %b required %b", bus.out_data, exp);
        end else begin
            bus.out_ack = ~bus.out_ack;
        end
    endtask

    task automatic check_reset_state(input string tag);
        n_vectors++;
        if (bus.in_ack !== 1'b0 || bus.out_req !== 1'b0 || bus.out_data !== '0 ||
            level !== '0 || empty !== 1'b1 || full !== 1'b0) begin
            n_miscompares++;
            $display("[TB] FAIL %s: in_ack=%b out_req=%b out_data=%b level=%0d empty=%b full=%b required 0 0 00 0 1 0",
                     tag, bus.in_ack, bus.out_req, bus.out_data, level, empty, full);
        end
    endtask

    task automatic test_reset();
        reset       = 1'b1;
        bus.in_req  = 1'b0;
        bus.out_ack = 1'b0;
        bus.in_data = '0;
        step();
        step();
        check_reset_state("reset_state");
        reset = 1'b0;
        step();
        check_reset_state("idle_after_reset");
    endtask

    task automatic test_latency();
        int in_edge  = 0;
        int out_edge = 0;
        bus.in_data = 2'b10;
        bus.in_req  = ~bus.in_req;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (in_edge == 0 && bus.in_ack === bus.in_req) in_edge = k;
            if (out_edge == 0 && bus.out_req !== bus.out_ack) out_edge = k;
        end
        n_vectors++;
        if (in_edge != IN_LAT) begin
            n_miscompares++;
            $display("[TB] FAIL in_ack_latency: edge %0d required %0d", in_edge, IN_LAT);
        end
        n_vectors++;
        if (out_edge != OUT_LAT) begin
            n_miscompares++;
            $display("[TB] FAIL out_req_latency: edge %0d required %0d", out_edge, OUT_LAT);
        end
        n_vectors++;
        if (bus.out_data !== 2'b10) begin
            n_miscompares++;
            $display("[TB] FAIL latency_data: got %b required 10", bus.out_data);
        end
        bus.out_ack = ~bus.out_ack;
        for (int k = 0; k < 4; k++) step();
        n_vectors++;
        if (empty !== 1'b1 || level !== '0) begin
            n_miscompares++;
            $display("[TB] FAIL drained: level=%0d empty=%b required 0 1", level, empty);
        end
    endtask

    task automatic test_fill();
        logic [DW-1:0] w;
        for (int i = 0; i < 5; i++) begin
            w = DW'(i % 4);
            send_word(w);
        end
        for (int k = 0; k < 4; k++) step();
        n_vectors++;
        if (level !== CW'(DEPTH) || full !== 1'b1 || empty !== 1'b0) begin
            n_miscompares++;
            $display("[TB] FAIL fill_level: level=%0d full=%b required %0d 1", level, full, DEPTH);
        end
        // Sixth word must stay pending while the output is held.
        bus.in_data = 2'b01;
        bus.in_req  = ~bus.in_req;
        sb.push_back(2'b01);
        for (int k = 0; k < 8; k++) step();
        n_vectors++;
        if (bus.in_ack === bus.in_req) begin
            n_miscompares++;
            $display("[TB] FAIL full_blocks_write: in_ack=%b required %b", bus.in_ack, ~bus.in_req);
        end
    endtask

    task automatic test_full_release();
        int k;
        recv_word();
        k = 0;
        while (level === CW'(DEPTH) && k < 20) begin
            step();
            k++;
        end
        n_vectors++;
        if (level !== CW'(DEPTH - 1) || bus.in_ack === bus.in_req) begin
            n_miscompares++;
            $display("[TB] FAIL release_read: level=%0d in_pend=%b required %0d 1",
                     level, bus.in_ack ^ bus.in_req, DEPTH - 1);
        end
        step();
        n_vectors++;
        if (level !== CW'(DEPTH) || bus.in_ack !== bus.in_req) begin
            n_miscompares++;
            $display("[TB] FAIL release_write: level=%0d in_ack=%b required %0d %b",
                     level, bus.in_ack, DEPTH, bus.in_req);
        end
        for (int i = 0; i < 5; i++) recv_word();
        for (int k2 = 0; k2 < 6; k2++) step();
        n_vectors++;
        if (empty !== 1'b1 || sb.size() != 0) begin
            n_miscompares++;
            $display("[TB] FAIL order_drain: empty=%b left=%0d required 1 0", empty, sb.size());
        end
    endtask

    task automatic test_reset_midway();
        logic [DW-1:0] w;
        for (int i = 0; i < 4; i++) begin
            w = DW'(3 - i);
            send_word(w);
        end
        for (int k = 0; k < 6; k++) step();
        n_vectors++;
        if (level !== CW'(3) || bus.out_req === bus.out_ack) begin
            n_miscompares++;
            $display("[TB] FAIL pre_reset: level=%0d out_busy=%b required 3 1",
                     level, bus.out_req ^ bus.out_ack);
        end
        reset       = 1'b1;
        bus.in_req  = 1'b0;
        bus.out_ack = 1'b0;
        step();
        step();
        check_reset_state("mid_reset");
        reset = 1'b0;
        sb.delete();
        step();
        send_word(2'b01);
        recv_word();
        for (int k = 0; k < 6; k++) step();
    endtask

    task automatic test_back_to_back();
        fork
            begin
                logic [DW-1:0] w;
                for (int i = 0; i < 100; i++) begin
                    w = DW'($urandom_range(0, 3));
                    send_word(w);
                    if ($urandom_range(0, 3) == 0) step();
                end
            end
            begin
                for (int j = 0; j < 100; j++) begin
                    recv_word();
                    for (int d = $urandom_range(0, 2); d > 0; d--) step();
                end
            end
        join
        for (int k = 0; k < 6; k++) step();
        n_vectors++;
        if (empty !== 1'b1 || sb.size() != 0) begin
            n_miscompares++;
            $display("[TB] FAIL stream_drain: empty=%b left=%0d required 1 0", empty, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_fill();
        test_full_release();
        test_reset_midway();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "[TB] timeout");
    end
endmodule
